ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/ex_alu_stage_if.sv | 43 ++++
 rtl/ex_alu_stage.sv | 112 +++++++++++
 tb/tb_ex_alu_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_stage_if.sv
// EX-stage bus: the ID/EX slot presented to the ALU stage and the EX/MEM slot it returns.
interface ex_alu_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic [2:0]      operation;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            alusrc;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rd;
  logic            regwrite;
  logic            memread;
  logic            memwrite;
  logic            stall;
  logic            flush;

  logic            valid_out;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic            zero;
  logic [4:0]      rd_out;
  logic            regwrite_out;
  logic            memread_out;
  logic            memwrite_out;

  modport master (
    output valid_in, operation, rs1_data, rs2_data, imm, alusrc, fwd_a, fwd_b,
           wb_data, rd, regwrite, memread, memwrite, stall, flush,
    input  valid_out, alu_result, store_data, zero, rd_out, regwrite_out,
           memread_out, memwrite_out
  );

  modport slave (
    input  valid_in, operation, rs1_data, rs2_data, imm, alusrc, fwd_a, fwd_b,
           wb_data, rd, regwrite, memread, memwrite, stall, flush,
    output valid_out, alu_result, store_data, zero, rd_out, regwrite_out,
           memread_out, memwrite_out
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Pipeline EX stage: operand forwarding, ALU, and the EX/MEM register with stall/flush.
module ex_alu_stage #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  ex_alu_stage_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic signed [XLEN-1:0] op_a_p0;
  logic signed [XLEN-1:0] rs2_fwd_p0;
  logic signed [XLEN-1:0] op_b_p0;
  logic signed [XLEN-1:0] result_p0;

  logic                   vld_p1;
  logic signed [XLEN-1:0] result_p1;
  logic signed [XLEN-1:0] store_p1;
  logic                   zero_p1;
  logic [4:0]             rd_p1;
  logic                   regwrite_p1;
  logic                   memread_p1;
  logic                   memwrite_p1;

  // Select 11 falls back to the register file, like 00.
  function automatic logic signed [XLEN-1:0] fwd_sel(
    input logic [1:0]             sel,
    input logic signed [XLEN-1:0] regfile,
    input logic signed [XLEN-1:0] wb,
    input logic signed [XLEN-1:0] own
  );
    logic signed [XLEN-1:0] v;
    case (sel)
      2'b01:   v = wb;
      2'b10:   v = own;
      default: v = regfile;
    endcase
    return v;
  endfunction

  // Undefined or unknown codes never match a case item and yield zero.
  function automatic logic signed [XLEN-1:0] alu_op(
    input logic [2:0]             op,
    input logic signed [XLEN-1:0] a,
    input logic signed [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = (a < b) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: forwarding mux and ALU on the live ID/EX slot
  always_comb begin
    op_a_p0    = fwd_sel(bus.fwd_a, bus.rs1_data, bus.wb_data, result_p1);
    rs2_fwd_p0 = fwd_sel(bus.fwd_b, bus.rs2_data, bus.wb_data, result_p1);
    op_b_p0    = bus.alusrc ? bus.imm : rs2_fwd_p0;
    result_p0  = alu_op(bus.operation, op_a_p0, op_b_p0);
  end

  // Stage p1: EX/MEM register; flush beats stall, stall holds, idle slot becomes a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      result_p1   <= '0;
      store_p1    <= '0;
      zero_p1     <= 1'b0;
      rd_p1       <= '0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
    end else if (bus.flush || (!bus.stall && !bus.valid_in)) begin
      vld_p1      <= 1'b0;
      result_p1   <= '0;
      store_p1    <= '0;
      zero_p1     <= 1'b0;
      rd_p1       <= '0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1      <= 1'b1;
      result_p1   <= result_p0;
      store_p1    <= rs2_fwd_p0;
      zero_p1     <= (result_p0 == '0);
      rd_p1       <= bus.rd;
      regwrite_p1 <= bus.regwrite;
      memread_p1  <= bus.memread;
      memwrite_p1 <= bus.memwrite;
    end
  end

  assign bus.valid_out    = vld_p1;
  assign bus.alu_result   = result_p1;
  assign bus.store_data   = store_p1;
  assign bus.zero         = zero_p1;
  assign bus.rd_out       = rd_p1;
  assign bus.regwrite_out = regwrite_p1;
  assign bus.memread_out  = memread_p1;
  assign bus.memwrite_out = memwrite_p1;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed vector table, stall/flush/reset sequences, random vs. model.
module tb_ex_alu_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_alu_stage_if #(.XLEN(XLEN)) bus ();

  ex_alu_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        stall;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        alusrc;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } model_t;

  typedef struct {
    in_t         in;
    logic        exp_valid;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic [31:0] exp_store;
  } vec_t;

  int checks = 0;
  int errors = 0;
  model_t m;

  function automatic in_t idle_in();
    in_t x;
    x = '{valid: 1'b0, stall: 1'b0, flush: 1'b0, op: 3'd0, rs1: 32'd0, rs2: 32'd0,
          imm: 32'd0, alusrc: 1'b0, fwd_a: 2'd0, fwd_b: 2'd0, wb: 32'd0, rd: 5'd0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return x;
  endfunction

  function automatic model_t empty_model();
    model_t e;
    e = '{valid: 1'b0, result: 32'd0, store: 32'd0, zero: 1'b0, rd: 5'd0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return e;
  endfunction

  // Reference: what the EX/MEM slot should hold after one edge, from the instruction semantics.
  function automatic model_t model_next(model_t cur, in_t x);
    model_t n;
    int signed sa, sb;
    logic [31:0] a, s, b, r;
    if (x.flush || (!x.stall && !x.valid)) return empty_model();
    if (x.stall) return cur;
    a = (x.fwd_a == 2'd1) ? x.wb : (x.fwd_a == 2'd2) ? cur.result : x.rs1;
    s = (x.fwd_b == 2'd1) ? x.wb : (x.fwd_b == 2'd2) ? cur.result : x.rs2;
    b = x.alusrc ? x.imm : s;
    sa = a;
    sb = b;
    case (x.op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd5:    r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    n = '{valid: 1'b1, result: r, store: s, zero: (r == 32'd0), rd: x.rd,
          rw: x.rw, mr: x.mr, mw: x.mw};
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid_out"},    32'(bus.valid_out),    32'(m.valid));
    chk({tag, ".alu_result"},   bus.alu_result,        m.result);
    chk({tag, ".store_data"},   bus.store_data,        m.store);
    chk({tag, ".zero"},         32'(bus.zero),         32'(m.zero));
    chk({tag, ".rd_out"},       32'(bus.rd_out),       32'(m.rd));
    chk({tag, ".regwrite_out"}, 32'(bus.regwrite_out), 32'(m.rw));
    chk({tag, ".memread_out"},  32'(bus.memread_out),  32'(m.mr));
    chk({tag, ".memwrite_out"}, 32'(bus.memwrite_out), 32'(m.mw));
  endtask

  task automatic drive(input in_t x);
    bus.valid_in  = x.valid;
    bus.stall     = x.stall;
    bus.flush     = x.flush;
    bus.operation = x.op;
    bus.rs1_data  = x.rs1;
    bus.rs2_data  = x.rs2;
    bus.imm       = x.imm;
    bus.alusrc    = x.alusrc;
    bus.fwd_a     = x.fwd_a;
    bus.fwd_b     = x.fwd_b;
    bus.wb_data   = x.wb;
    bus.rd        = x.rd;
    bus.regwrite  = x.rw;
    bus.memread   = x.mr;
    bus.memwrite  = x.mw;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic step(input in_t x);
    drive(x);
    @(posedge clk);
    #1;
    m = model_next(m, x);
  endtask

  function automatic in_t mk(logic [2:0] op, logic [31:0] rs1, logic [31:0] rs2,
                             logic [31:0] imm, logic alusrc, logic [1:0] fa,
                             logic [1:0] fb, logic [31:0] wb);
    in_t x;
    x = idle_in();
    x.valid = 1'b1; x.op = op; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm;
    x.alusrc = alusrc; x.fwd_a = fa; x.fwd_b = fb; x.wb = wb;
    x.rd = 5'd3; x.rw = 1'b1;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    in_t x;
    vec_t v;

    reset = 1'b1;
    drive(idle_in());
    m = empty_model();
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset_state");
    reset = 1'b0;

    // Directed table; entries run back-to-back, so forwarding of 10 sees the previous row.
    v.in = mk(3'b001, 32'd7, 32'd5, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'd2; v.exp_zero = 1'b0; v.exp_store = 32'd5; vecs.push_back(v);
    v.in = mk(3'b000, 32'hFFFF_FFFF, 32'd9, 32'd1, 1'b1, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'd0; v.exp_zero = 1'b1; v.exp_store = 32'd9; vecs.push_back(v);
    v.in = mk(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'd1; v.exp_zero = 1'b0; v.exp_store = 32'd1; vecs.push_back(v);
    v.in = mk(3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'd0; v.exp_zero = 1'b1; v.exp_store = 32'hFFFF_FFFF; vecs.push_back(v);
    v.in = mk(3'b000, 32'h10, 32'd0, 32'd0, 1'b1, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'h10; v.exp_zero = 1'b0; v.exp_store = 32'd0; vecs.push_back(v);
    v.in = mk(3'b000, 32'hDEAD, 32'd0, 32'd4, 1'b1, 2'd2, 2'd0, 32'h100);
    v.exp_valid = 1'b1; v.exp_result = 32'h14; v.exp_zero = 1'b0; v.exp_store = 32'd0; vecs.push_back(v);
    v.in = mk(3'b000, 32'hDEAD, 32'd0, 32'd4, 1'b1, 2'd1, 2'd0, 32'h100);
    v.exp_valid = 1'b1; v.exp_result = 32'h104; v.exp_zero = 1'b0; v.exp_store = 32'd0; vecs.push_back(v);
    v.in = mk(3'b001, 32'd0, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'hFFFF_FFFF; v.exp_zero = 1'b0; v.exp_store = 32'd1; vecs.push_back(v);
    v.in = mk(3'b010, 32'h3F, 32'h0F, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'h0F; v.exp_zero = 1'b0; v.exp_store = 32'h0F; vecs.push_back(v);
    v.in = mk(3'b011, 32'hF0, 32'h0F, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'hFF; v.exp_zero = 1'b0; v.exp_store = 32'h0F; vecs.push_back(v);
    v.in = mk(3'b000, 32'd1, 32'd0, 32'd0, 1'b0, 2'd3, 2'd2, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'h100; v.exp_zero = 1'b0; v.exp_store = 32'hFF; vecs.push_back(v);
    v.in = mk(3'b100, 32'd6, 32'd6, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.exp_valid = 1'b1; v.exp_result = 32'd0; v.exp_zero = 1'b1; v.exp_store = 32'd6; vecs.push_back(v);
    v.in = mk(3'b000, 32'd1, 32'd77, 32'd0, 1'b0, 2'd0, 2'd1, 32'd5);
    v.in.mw = 1'b1; v.in.mr = 1'b1; v.in.rw = 1'b0;
    v.exp_valid = 1'b1; v.exp_result = 32'd6; v.exp_zero = 1'b0; v.exp_store = 32'd5; vecs.push_back(v);
    v.in = mk(3'b000, 32'd9, 32'd9, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    v.in.valid = 1'b0;
    v.exp_valid = 1'b0; v.exp_result = 32'd0; v.exp_zero = 1'b0; v.exp_store = 32'd0; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].in);
      chk({tag, ".valid_out"},  32'(bus.valid_out), 32'(vecs[i].exp_valid));
      chk({tag, ".alu_result"}, bus.alu_result,     vecs[i].exp_result);
      chk({tag, ".zero"},       32'(bus.zero),      32'(vecs[i].exp_zero));
      chk({tag, ".store_data"}, bus.store_data,     vecs[i].exp_store);
      chk({tag, ".rd_out"},       32'(bus.rd_out),       32'(m.rd));
      chk({tag, ".regwrite_out"}, 32'(bus.regwrite_out), 32'(m.rw));
      chk({tag, ".memread_out"},  32'(bus.memread_out),  32'(m.mr));
      chk({tag, ".memwrite_out"}, 32'(bus.memwrite_out), 32'(m.mw));
    end

    // Stall holds the slot through changing inputs; release forwards the held value.
    step(mk(3'b010, 32'h3F, 32'h0F, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0));
    chk("and_load.alu_result", bus.alu_result, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      x = mk(3'(i), $urandom, $urandom, $urandom, 1'b1, 2'd2, 2'd1, $urandom);
      x.stall = 1'b1;
      step(x);
      chk($sformatf("stall%0d.alu_result", i), bus.alu_result, 32'h0F);
      chk($sformatf("stall%0d.valid_out", i), 32'(bus.valid_out), 32'd1);
      chk($sformatf("stall%0d.store_data", i), bus.store_data, 32'h0F);
    end
    step(mk(3'b000, 32'hAAAA, 32'd0, 32'd1, 1'b1, 2'd2, 2'd0, 32'd0));
    chk("stall_release_fwd.alu_result", bus.alu_result, 32'h10);
    x = mk(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    x.stall = 1'b1;
    x.flush = 1'b1;
    step(x);
    chk("stall_flush.valid_out", 32'(bus.valid_out), 32'd0);
    chk("stall_flush.regwrite_out", 32'(bus.regwrite_out), 32'd0);
    chk_model("stall_flush");

    // Asynchronous reset mid-cycle while stalled and flushed, then an undefined op.
    step(mk(3'b000, 32'd3, 32'd4, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0));
    chk("pre_reset.valid_out", 32'(bus.valid_out), 32'd1);
    x = mk(3'b000, 32'd3, 32'd4, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0);
    x.stall = 1'b1;
    x.flush = 1'b1;
    drive(x);
    #2;
    reset = 1'b1;
    #1;
    m = empty_model();
    chk_model("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_model("reset_held");
    step(mk(3'b111, 32'd5, 32'd6, 32'd0, 1'b0, 2'd0, 2'd0, 32'd0));
    chk("op111.alu_result", bus.alu_result, 32'd0);
    chk("op111.zero", 32'(bus.zero), 32'd1);
    chk("op111.valid_out", 32'(bus.valid_out), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      x = idle_in();
      x.valid  = ($urandom_range(0, 9) < 8);
      x.stall  = ($urandom_range(0, 9) < 2);
      x.flush  = ($urandom_range(0, 9) == 0);
      x.op     = 3'($urandom_range(0, 7));
      x.rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      x.rs2    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      x.imm    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      x.alusrc = 1'($urandom_range(0, 1));
      x.fwd_a  = 2'($urandom_range(0, 3));
      x.fwd_b  = 2'($urandom_range(0, 3));
      x.wb     = $urandom;
      x.rd     = 5'($urandom_range(0, 31));
      x.rw     = 1'($urandom_range(0, 1));
      x.mr     = 1'($urandom_range(0, 1));
      x.mw     = 1'($urandom_range(0, 1));
      step(x);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
